// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state type, coin codes and coin decoding for the vending controller
package vend_pkg;

  localparam int CREDIT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vend_state_e;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  // Value of a coin in 5-cent units; the invalid code is worth nothing.
  function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] code);
    case (code)
      COIN_NICKEL:  coin_units = 4'd1;
      COIN_DIME:    coin_units = 4'd2;
      COIN_QUARTER: coin_units = 4'd5;
      default:      coin_units = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// rtl/vend_pulse_timer.sv - down-counter that holds the dispense strobe for a fixed number of cycles
module vend_pulse_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic active,
  output logic done
);

  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter register; reset abandons any pulse in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Load on start so the strobe is high from the next cycle, then count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Strobe while counting; done marks the final strobe cycle so the owner can leave next cycle.
  always_comb begin
    active = (cnt_q != '0);
    done   = (cnt_q == ONE);
  end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin credit, dispense and change sequencer for the vending machine
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS     = 5,
  parameter int DISPENSE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  output logic                coin_accept,
  output logic                coin_reject,
  input  logic                cancel,
  output logic                dispense,
  output logic                change_nickel,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W:0] PRICE = (CREDIT_W + 1)'(PRICE_UNITS);

  vend_state_e         state_q;
  vend_state_e         state_d;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] credit_d;
  logic                coin_reject_q;
  logic                coin_reject_d;

  logic                coin_taken;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W:0]   vend_rem;
  logic                timer_start;
  logic                timer_active;
  logic                timer_done;

  vend_pulse_timer #(
    .CYCLES (DISPENSE_CYCLES)
  ) u_dispense_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (timer_start),
    .active (timer_active),
    .done   (timer_done)
  );

  // State, credit and reject-pulse registers; reset drops any vend or refund in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // Next state: accumulate coins, vend at price, refund on cancel, pay change one nickel per ack.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    timer_start = 1'b0;

    coin_taken    = coin_valid && coin_accept && (coin_code != COIN_NONE);
    coin_reject_d = coin_valid && !coin_taken;

    // 5-bit sum so an out-of-range price setting cannot silently wrap the compare.
    sum      = {1'b0, credit_q} + (coin_taken ? {1'b0, coin_units(coin_code)} : '0);
    vend_rem = sum - PRICE;

    case (state_q)
      IDLE, CREDIT: begin
        if (cancel) begin
          // Cancel wins over a vend, so a price-reaching coin in the same cycle is refunded too.
          if (sum != '0) begin
            state_d  = CHANGE;
            credit_d = sum[CREDIT_W-1:0];
          end else begin
            state_d  = IDLE;
            credit_d = '0;
          end
        end else if (coin_taken) begin
          if (sum >= PRICE) begin
            state_d     = DISPENSE;
            credit_d    = vend_rem[CREDIT_W-1:0];
            timer_start = 1'b1;
          end else begin
            state_d  = CREDIT;
            credit_d = sum[CREDIT_W-1:0];
          end
        end
      end
      DISPENSE: begin
        if (timer_done) begin
          state_d = (credit_q != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        if (change_ack && change_nickel) begin
          credit_d = credit_q - 1'b1;
          if (credit_q == 4'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    coin_accept   = (state_q == IDLE) || (state_q == CREDIT);
    busy          = (state_q == DISPENSE) || (state_q == CHANGE);
    change_nickel = (state_q == CHANGE) && (credit_q != '0);
    coin_reject   = coin_reject_q;
    credit        = credit_q;
    dispense      = timer_active;
  end

  // Credit headroom: the largest reachable sum is PRICE-1 plus a quarter.
  a_sum_fits: assert property (@(posedge clk) disable iff (reset) coin_taken |-> (sum <= 5'd15));

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - scoreboard bench for vend_controller with directed vectors
module tb_vend_controller;

  localparam logic [1:0] NO = 2'b00;
  localparam logic [1:0] NK = 2'b01;
  localparam logic [1:0] DM = 2'b10;
  localparam logic [1:0] QT = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = 2'b00;
  logic       coin_accept;
  logic       coin_reject;
  logic       cancel = 1'b0;
  logic       dispense;
  logic       change_nickel;
  logic       change_ack = 1'b0;
  logic [3:0] credit;
  logic       busy;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  vend_controller #(
    .PRICE_UNITS     (5),
    .DISPENSE_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .coin_valid    (coin_valid),
    .coin_code     (coin_code),
    .coin_accept   (coin_accept),
    .coin_reject   (coin_reject),
    .cancel        (cancel),
    .dispense      (dispense),
    .change_nickel (change_nickel),
    .change_ack    (change_ack),
    .credit        (credit),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Pack expected outputs: accept, reject, dispense, change_nickel, credit, busy.
  function automatic logic [8:0] e(input logic a, input logic r, input logic d, input logic c,
                                   input logic [3:0] cr, input logic b);
    e = {a, r, d, c, cr, b};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the following clock edge.
  task automatic step(input logic rst, input logic cv, input logic [1:0] code, input logic cn,
                      input logic ack, input logic [8:0] exp, input string name);
    exp_t item;
    @(negedge clk);
    reset      = rst;
    coin_valid = cv;
    coin_code  = code;
    cancel     = cn;
    change_ack = ack;
    item.name  = name;
    item.exp   = exp;
    exp_q.push_back(item);
  endtask

  // Monitor: after every edge, compare the presented outputs with the oldest queued expectation.
  initial begin
    exp_t       item;
    logic [8:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        got  = {coin_accept, coin_reject, dispense, change_nickel, credit, busy};
        n_checks++;
        if (got === item.exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got acc=%b rej=%b disp=%b chg=%b credit=%0d busy=%b, expected acc=%b rej=%b disp=%b chg=%b credit=%0d busy=%b",
                   item.name, got[8], got[7], got[6], got[5], got[4:1], got[0],
                   item.exp[8], item.exp[7], item.exp[6], item.exp[5], item.exp[4:1], item.exp[0]);
        end
      end
    end
  end

  initial begin
    step(1, 0, NO, 0, 0, e(1, 0, 0, 0, 0, 0), "reset");

    // Five nickels reach the price exactly: vend with no change.
    for (int i = 1; i <= 4; i++) step(0, 1, NK, 0, 0, e(1, 0, 0, 0, 4'(i), 0), "t1_nickel");
    step(0, 1, NK, 0, 0, e(0, 0, 1, 0, 0, 1), "t1_nickel5_vend");
    for (int i = 0; i < 3; i++) step(0, 0, NO, 0, 0, e(0, 0, 1, 0, 0, 1), "t1_disp_hold");
    step(0, 0, NO, 0, 0, e(1, 0, 0, 0, 0, 0), "t1_idle");

    // Quarter on credit 4: vend, then four nickels of change acked every other cycle.
    step(0, 1, DM, 0, 0, e(1, 0, 0, 0, 2, 0), "t2_dime1");
    step(0, 1, DM, 0, 0, e(1, 0, 0, 0, 4, 0), "t2_dime2");
    step(0, 1, QT, 0, 0, e(0, 0, 1, 0, 4, 1), "t2_quarter_vend");
    for (int i = 0; i < 3; i++) step(0, 0, NO, 0, 0, e(0, 0, 1, 0, 4, 1), "t2_disp_hold");
    step(0, 0, NO, 0, 0, e(0, 0, 0, 1, 4, 1), "t2_change_entry");
    for (int i = 3; i >= 1; i--) begin
      step(0, 0, NO, 0, 1, e(0, 0, 0, 1, 4'(i), 1), "t2_ack");
      step(0, 0, NO, 0, 0, e(0, 0, 0, 1, 4'(i), 1), "t2_noack");
    end
    step(0, 0, NO, 0, 1, e(1, 0, 0, 0, 0, 0), "t2_last_ack");

    // Two dimes then cancel: refund of 4 with no vend.
    step(0, 1, DM, 0, 0, e(1, 0, 0, 0, 2, 0), "t3_dime1");
    step(0, 1, DM, 0, 0, e(1, 0, 0, 0, 4, 0), "t3_dime2");
    step(0, 0, NO, 1, 0, e(0, 0, 0, 1, 4, 1), "t3_cancel");
    for (int i = 3; i >= 1; i--) step(0, 0, NO, 0, 1, e(0, 0, 0, 1, 4'(i), 1), "t3_ack");
    step(0, 0, NO, 0, 1, e(1, 0, 0, 0, 0, 0), "t3_last_ack");

    // Coin and cancel during dispense are refused/ignored; invalid code refused in IDLE and CREDIT.
    step(0, 1, QT, 0, 0, e(0, 0, 1, 0, 0, 1), "t4_quarter_vend");
    step(0, 1, NK, 1, 0, e(0, 1, 1, 0, 0, 1), "t4_coin_in_disp");
    step(0, 0, NO, 0, 0, e(0, 0, 1, 0, 0, 1), "t4_reject_drop");
    step(0, 0, NO, 0, 0, e(0, 0, 1, 0, 0, 1), "t4_disp_last");
    step(0, 0, NO, 0, 0, e(1, 0, 0, 0, 0, 0), "t4_idle");
    step(0, 1, NO, 0, 0, e(1, 1, 0, 0, 0, 0), "t4_code00_idle");
    step(0, 0, NO, 0, 0, e(1, 0, 0, 0, 0, 0), "t4_reject_drop2");
    step(0, 1, NK, 0, 0, e(1, 0, 0, 0, 1, 0), "t4_nickel");
    step(0, 1, NO, 0, 0, e(1, 1, 0, 0, 1, 0), "t4_code00_credit");
    step(0, 0, NO, 0, 0, e(1, 0, 0, 0, 1, 0), "t4_credit_kept");
    step(0, 0, NO, 1, 0, e(0, 0, 0, 1, 1, 1), "t4_cancel_one");
    step(0, 0, NO, 0, 1, e(1, 0, 0, 0, 0, 0), "t4_ack_one_to_zero");
    step(0, 0, NO, 0, 1, e(1, 0, 0, 0, 0, 0), "t4_ack_in_idle");
    step(0, 0, NO, 1, 0, e(1, 0, 0, 0, 0, 0), "t4_cancel_zero");

    // Credit 3 plus dime with cancel: refund 5, no vend.
    step(0, 1, NK, 0, 0, e(1, 0, 0, 0, 1, 0), "t5_nickel");
    step(0, 1, DM, 0, 0, e(1, 0, 0, 0, 3, 0), "t5_dime");
    step(0, 1, DM, 1, 0, e(0, 0, 0, 1, 5, 1), "t5_dime_cancel");
    for (int i = 4; i >= 1; i--) step(0, 0, NO, 0, 1, e(0, 0, 0, 1, 4'(i), 1), "t5_ack");
    step(0, 0, NO, 0, 1, e(1, 0, 0, 0, 0, 0), "t5_last_ack");

    // Exact-price quarter with cancel refunds; coin offered during change is refused.
    step(0, 1, QT, 1, 0, e(0, 0, 0, 1, 5, 1), "t5_quarter_cancel");
    step(0, 1, NK, 0, 1, e(0, 1, 0, 1, 4, 1), "t5_coin_in_change");
    for (int i = 3; i >= 1; i--) step(0, 0, NO, 0, 1, e(0, 0, 0, 1, 4'(i), 1), "t5_ack2");
    step(0, 0, NO, 0, 1, e(1, 0, 0, 0, 0, 0), "t5_last_ack2");

    // Reset on the second dispense cycle abandons the vend and the change due.
    step(0, 1, NK, 0, 0, e(1, 0, 0, 0, 1, 0), "t6_nickel");
    step(0, 1, QT, 0, 0, e(0, 0, 1, 0, 1, 1), "t6_quarter_vend");
    step(1, 0, NO, 0, 0, e(1, 0, 0, 0, 0, 0), "t6_reset_mid_disp");
    step(0, 0, NO, 0, 0, e(1, 0, 0, 0, 0, 0), "t6_idle_after");

    @(negedge clk);
    coin_valid = 1'b0;
    cancel     = 1'b0;
    change_ack = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d expectations left, expected 0", exp_q.size());
      n_checks = n_checks + exp_q.size();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
